// File: rtl/router_pkt_src_if.sv
// Host-side command and payload handshake feeding router_pkt_src.
interface router_pkt_src_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       pld_valid;
  logic       pld_ready;
  logic [7:0] pld_data;

  modport master (output cmd_valid, cmd_addr, cmd_len, pld_valid, pld_data,
                  input  cmd_ready, pld_ready);
  modport slave  (input  cmd_valid, cmd_addr, cmd_len, pld_valid, pld_data,
                  output cmd_ready, pld_ready);
endinterface

// File: rtl/router_pkt_src.sv
// Store-and-forward packet source: buffers a whole payload, then emits
// header / payload / parity to the 1x3 router and reports per-packet status.
module router_pkt_src #(
  parameter int GAP_CYCLES = 3,
  parameter int BUSY_TMO   = 255
) (
  input  logic            clock,
  input  logic            resetn,
  router_pkt_src_if.slave host,
  input  logic            busy,
  input  logic            err,
  output logic [7:0]      pkt_data,
  output logic            pkt_valid,
  output logic            pkt_done,
  output logic            pkt_err,
  output logic            bad_cmd,
  output logic            tmo
);
  localparam int              GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]   GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [7:0]      BUSY_LAST = 8'(BUSY_TMO - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HDR, S_PLD, S_PAR, S_GAP} state_t;

  state_t        r_state;
  logic          r_cmd_ready;
  logic          r_pld_ready;
  logic [7:0]    r_pkt_data;
  logic          r_pkt_valid;
  logic          r_pkt_done;
  logic          r_pkt_err;
  logic          r_bad_cmd;
  logic          r_tmo;
  logic [1:0]    r_addr;
  logic [5:0]    r_len;
  logic [5:0]    r_wcnt;
  logic [5:0]    r_ridx;
  logic [7:0]    r_par;
  logic [7:0]    r_bcnt;
  logic [GW-1:0] r_gcnt;
  logic          r_flag;
  logic [7:0]    r_buf [64];

  logic       w_cmd_fire;
  logic       w_pld_fire;
  logic       w_cmd_bad;
  logic       w_tmo_hit;
  logic [5:0] w_len_m1;
  logic [5:0] w_ridx_nxt;
  logic [7:0] w_header;

  assign w_cmd_fire = host.cmd_valid & r_cmd_ready;
  assign w_pld_fire = host.pld_valid & r_pld_ready;
  assign w_cmd_bad  = (host.cmd_addr == 2'd3) || (host.cmd_len == 6'd0);
  assign w_tmo_hit  = busy && (r_bcnt == BUSY_LAST);
  assign w_len_m1   = r_len - 6'd1;
  assign w_ridx_nxt = r_ridx + 6'd1;
  assign w_header   = {r_len, r_addr};

  assign host.cmd_ready = r_cmd_ready;
  assign host.pld_ready = r_pld_ready;
  assign pkt_data       = r_pkt_data;
  assign pkt_valid      = r_pkt_valid;
  assign pkt_done       = r_pkt_done;
  assign pkt_err        = r_pkt_err;
  assign bad_cmd        = r_bad_cmd;
  assign tmo            = r_tmo;

  // NOTE: the payload buffer has no reset; every byte is written in LOAD
  // before it can be read, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clock) begin
    if (r_state == S_LOAD && w_pld_fire) r_buf[r_wcnt] <= host.pld_data;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // sees pre-edge values, regardless of statement order.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_pld_ready <= 1'b0;
      r_pkt_data  <= 8'h00;
      r_pkt_valid <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_pkt_err   <= 1'b0;
      r_bad_cmd   <= 1'b0;
      r_tmo       <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_wcnt      <= '0;
      r_ridx      <= '0;
      r_par       <= '0;
      r_bcnt      <= '0;
      r_gcnt      <= '0;
      r_flag      <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      r_pkt_err  <= 1'b0;
      r_bad_cmd  <= 1'b0;
      r_tmo      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_cmd_fire) begin
            if (w_cmd_bad) begin
              r_bad_cmd <= 1'b1;
            end else begin
              r_addr      <= host.cmd_addr;
              r_len       <= host.cmd_len;
              r_par       <= {host.cmd_len, host.cmd_addr};
              r_wcnt      <= '0;
              r_cmd_ready <= 1'b0;
              r_pld_ready <= 1'b1;
              r_state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_pld_fire) begin
            r_par  <= r_par ^ host.pld_data;
            r_wcnt <= r_wcnt + 6'd1;
            if (r_wcnt == w_len_m1) begin
              r_pld_ready <= 1'b0;
              r_pkt_data  <= w_header;
              r_pkt_valid <= 1'b1;
              r_bcnt      <= '0;
              r_state     <= S_HDR;
            end
          end
        end
        S_HDR, S_PLD, S_PAR: begin
          if (w_tmo_hit) begin
            // Router stuck busy: drop the packet and report it as errored.
            r_tmo       <= 1'b1;
            r_pkt_valid <= 1'b0;
            r_pkt_data  <= 8'h00;
            r_bcnt      <= '0;
            r_flag      <= 1'b1;
            r_gcnt      <= '0;
            r_state     <= S_GAP;
          end else if (busy) begin
            r_bcnt <= r_bcnt + 8'd1;
          end else begin
            r_bcnt <= '0;
            if (r_state == S_HDR) begin
              r_pkt_data <= r_buf[0];
              r_ridx     <= '0;
              r_state    <= S_PLD;
            end else if (r_state == S_PLD) begin
              if (r_ridx == w_len_m1) begin
                r_pkt_data  <= r_par;
                r_pkt_valid <= 1'b0;
                r_state     <= S_PAR;
              end else begin
                r_ridx     <= w_ridx_nxt;
                r_pkt_data <= r_buf[w_ridx_nxt];
              end
            end else begin
              r_pkt_data <= 8'h00;
              r_flag     <= err;
              r_gcnt     <= '0;
              r_state    <= S_GAP;
            end
          end
        end
        S_GAP: begin
          r_flag <= r_flag | err;
          if (r_gcnt == GAP_LAST) begin
            r_pkt_done  <= 1'b1;
            r_pkt_err   <= r_flag | err;
            r_flag      <= 1'b0;
            r_gcnt      <= '0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/router_pkt_src.md
Name: router_pkt_src

Overview:
- Store-and-forward packet source that sits directly upstream of the 1x3 router top level.
- Takes a command (destination, length) and payload bytes from a host-side valid/ready interface, buffers the whole payload, then emits one router packet:
  - header byte {len[5:0], addr[1:0]} with pkt_valid=1
  - len payload bytes with pkt_valid=1
  - parity byte with pkt_valid=0
- Honours router busy and monitors router err to report per-packet status.

Parameters:
- GAP_CYCLES, 3: idle cycles after parity is accepted, before the next command; router err is sampled during this window.
- BUSY_TMO, 255: consecutive busy-high cycles in HDR/PLD/PAR that abort the packet.

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at an edge
- cmd_addr  in  2  destination port, 0..2
- cmd_len  in  6  payload length, 1..63
- pld_valid  in  1  payload byte offered
- pld_ready  out  1  payload byte accepted when pld_valid&&pld_ready at an edge
- pld_data  in  8  payload byte
- busy  in  1  router busy
- err  in  1  router parity error
- pkt_data  out  8  byte to router data_in
- pkt_valid  out  1  to router pkt_valid
- pkt_done  out  1  one-cycle pulse at packet end
- pkt_err  out  1  status qualified by pkt_done; 1 = router flagged err
- bad_cmd  out  1  one-cycle pulse when a command is rejected
- tmo  out  1  one-cycle pulse when a packet is aborted on busy timeout

Behaviour:
- All outputs are registered. The state machine has states IDLE, LOAD, HDR, PLD, PAR, GAP.
- Internal resources:
  - 64x8 payload buffer
  - 6-bit write count wcnt and read index ridx
  - 8-bit running parity par
  - latched addr/len
  - 8-bit busy counter
  - gap counter
- Reset (resetn=0 at an edge) takes effect from any state, including mid-packet, and gives:
  - state=IDLE, cmd_ready=0, pld_ready=0
  - pkt_data=8'h00, pkt_valid=0, pkt_done=0, pkt_err=0, bad_cmd=0, tmo=0
  - all counters 0
  - cmd_ready rises the cycle after reset releases.
- IDLE:
  - cmd_ready=1.
  - On an accepted command with addr==3 or len==0: bad_cmd pulses one cycle and the state stays IDLE.
  - Otherwise: latch addr and len, par<=header, wcnt<=0, go to LOAD.
- LOAD:
  - pld_ready=1, cmd_ready=0.
  - Each accepted byte does buf[wcnt]<=pld_data, par<=par^pld_data, wcnt++.
  - When the accepted byte has wcnt==len-1, go to HDR. In the next cycle pld_ready=0, pkt_data=header, pkt_valid=1.
- Transfer rule: the byte on pkt_data is consumed at an edge where busy==0. When busy==1, pkt_data and pkt_valid hold.
- HDR: on consume, go to PLD with pkt_data=buf[0] and ridx=0.
- PLD:
  - On consume with ridx==len-1: go to PAR with pkt_data=par and pkt_valid=0.
  - Otherwise: ridx++ and pkt_data=buf[ridx+1].
- PAR: on consume, go to GAP with pkt_data=0 and pkt_valid=0. Capture err at this edge into a sticky error flag.
- GAP:
  - Lasts GAP_CYCLES cycles; err is ORed into the sticky flag every cycle.
  - On the last cycle, pkt_done=1 and pkt_err=flag, then go to IDLE and clear the flag.
- No bubbles: between header and parity, pkt_valid never drops and no payload byte is skipped or repeated.
- Busy timeout:
  - In HDR, PLD or PAR, the busy counter increments while busy==1 and clears on any consume.
  - When it reaches BUSY_TMO: tmo pulses, pkt_valid<=0, pkt_data<=0, go to GAP. pkt_done then pulses with pkt_err=1.
- Payload bytes offered outside LOAD are ignored (pld_ready=0). Commands offered outside IDLE are not accepted.
- Packet length in cycles with busy always low: header + len + parity = len+2 cycles of output.

Test Plan:
- Reset and idle: hold resetn=0 for 2 cycles -> all outputs 0; cmd_ready=1 the cycle after release.
- Basic packet:
  - Stimulus: cmd addr=1 len=3; payload 0x11,0x22,0x33; busy=0.
  - Response: pkt_data sequence 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0; pkt_done pulses 3 cycles after parity is consumed with pkt_err=0.
- Busy stall: same packet with busy=1 for 4 cycles while 0x22 is presented -> 0x22 held 5 cycles, then the sequence continues with no loss or duplication.
- Reject: cmd addr=3 len=5, then cmd addr=0 len=0 -> bad_cmd pulses twice; state stays IDLE; pld_ready stays 0.
- Max length, addr=2 len=63, incrementing payload 0x00..0x3E -> header 0xFE; 63 payload bytes in order; parity = XOR of all bytes; then router err=1 asserted 1 cycle after parity consume -> pkt_err=1.
- Abort paths:
  - resetn=0 during PLD -> next-cycle pkt_valid=0 and state IDLE.
  - busy held high 255 cycles in HDR -> tmo pulse, then pkt_done with pkt_err=1.
